// File: rtl/seg_display_mux.sv
// seg_display_mux: multiplexed common-anode 7-segment driver with anode-off blanking,
// frame-synchronous double buffering, hex decode and leading-zero blanking.
module seg_display_mux #(
   parameter int NDIG         = 4,
   parameter int BLANK_CYCLES = 2
) (
   input  logic              clk,
   input  logic              greset,
   input  logic              digsel,
   input  logic [4*NDIG-1:0] data_in,
   input  logic              load,
   input  logic [NDIG-1:0]   dp_in,
   input  logic              lzb,
   output logic [NDIG-1:0]   an,
   output logic [6:0]        seg,
   output logic              dp,
   output logic              frame
);
   localparam int DW = 5*NDIG;
   localparam logic [3:0] CNT_INIT = 4'(BLANK_CYCLES == 0 ? 0 : BLANK_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
   localparam state_t AFTER_RISE = (BLANK_CYCLES == 0) ? SHOW : BLANK;
   state_t          state_q, state_d;
   logic [NDIG-1:0] ring_q, ring_d, an_q, an_d;
   logic [3:0]      cnt_q, cnt_d, nib;
   logic [DW-1:0]   staging_q, staging_d, shadow_q, shadow_d;
   logic [6:0]      seg_q, seg_d;
   logic            pending_q, pending_d, digsel_q, frame_q, frame_d, dp_q, dp_d;
   logic            rise, wrap, lz, dpa, show;
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction
   always_comb begin
      rise      = digsel & ~digsel_q;
      wrap      = rise && state_q != IDLE && ring_q[NDIG-1];
      state_d   = state_q;
      ring_d    = ring_q;
      cnt_d     = cnt_q;
      staging_d = load ? {dp_in, data_in} : staging_q;
      pending_d = load ? 1'b1 : pending_q;
      shadow_d  = shadow_q;
      frame_d   = wrap;
      case (state_q)
         IDLE: if (rise) begin
            state_d = AFTER_RISE;
            cnt_d   = CNT_INIT;
         end
         BLANK: if (rise) begin
            ring_d = {ring_q[NDIG-2:0], ring_q[NDIG-1]};
            cnt_d  = CNT_INIT;
         end else if (cnt_q == 4'd0) state_d = SHOW;
         else cnt_d = cnt_q - 4'd1;
         default: if (rise) begin
            ring_d  = {ring_q[NDIG-2:0], ring_q[NDIG-1]};
            state_d = AFTER_RISE;
            cnt_d   = CNT_INIT;
         end
      endcase
      // a load landing on the wrap edge bypasses staging so it shows in this frame
      if (wrap && (load || pending_q)) begin
         shadow_d  = load ? {dp_in, data_in} : staging_q;
         pending_d = 1'b0;
      end
      nib = '0;
      dpa = 1'b0;
      lz  = 1'b0;
      for (int i = 0; i < NDIG; i++)
         if (ring_d[i]) begin
            nib = shadow_d[4*i +: 4];
            dpa = shadow_d[4*NDIG + i];
            lz  = lzb && i > 0 && ((shadow_d[4*NDIG-1:0] >> (4*i)) == '0);
         end
      show  = state_d == SHOW;
      an_d  = show ? ~ring_d : '1;
      seg_d = (show && !lz) ? hex7(nib) : '1;
      dp_d  = show ? ~dpa : 1'b1;
   end
   always_ff @(posedge clk or posedge greset) begin
      if (greset) begin
         state_q   <= IDLE;
         ring_q    <= NDIG'(1);
         cnt_q     <= '0;
         staging_q <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         digsel_q  <= 1'b0;
         an_q      <= '1;
         seg_q     <= '1;
         dp_q      <= 1'b1;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ring_q    <= ring_d;
         cnt_q     <= cnt_d;
         staging_q <= staging_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         digsel_q  <= digsel;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         frame_q   <= frame_d;
      end
   end
   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign frame = frame_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed checks of scan order, blanking, double buffer, lzb and reset,
// with a second instance at BLANK_CYCLES=0 sharing the same stimulus.
module tb_seg_display_mux;
   logic        clk = 0, greset = 0, digsel = 0, load = 0, lzb = 0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  an, an1;
   logic [6:0]  seg, seg1;
   logic        dp, dp1, frame, frame1;
   int          total = 0, bad = 0;
   always #5 clk = ~clk;
   seg_display_mux #(.NDIG(4), .BLANK_CYCLES(2)) u0 (
      .clk(clk), .greset(greset), .digsel(digsel), .data_in(data_in), .load(load),
      .dp_in(dp_in), .lzb(lzb), .an(an), .seg(seg), .dp(dp), .frame(frame));
   seg_display_mux #(.NDIG(4), .BLANK_CYCLES(0)) u1 (
      .clk(clk), .greset(greset), .digsel(digsel), .data_in(data_in), .load(load),
      .dp_in(dp_in), .lzb(lzb), .an(an1), .seg(seg1), .dp(dp1), .frame(frame1));
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // one digit advance: two blank cycles on u0, immediate change on u1, then the digit
   task automatic adv(input logic [3:0] ea, input logic [6:0] es, input logic edp, input logic ef);
      digsel = 1;
      step(1);
      digsel = 0;
      load   = 0;
      chk("blank1_an", 8'(an), 8'hF);
      chk("blank1_seg", 8'(seg), 8'h7F);
      chk("frame", 8'(frame), 8'(ef));
      chk("b0_an", 8'(an1), 8'(ea));
      chk("b0_seg", 8'(seg1), 8'(es));
      step(1);
      chk("blank2_an", 8'(an), 8'hF);
      chk("frame_off", 8'(frame), 8'h0);
      step(1);
      chk("show_an", 8'(an), 8'(ea));
      chk("show_seg", 8'(seg), 8'(es));
      chk("show_dp", 8'(dp), 8'(edp));
      step(4);
      chk("hold_an", 8'(an), 8'(ea));
   endtask
   initial begin
      #1 greset = 1;
      #1;
      chk("rst_an", 8'(an), 8'hF);
      chk("rst_seg", 8'(seg), 8'h7F);
      chk("rst_dp", 8'(dp), 8'h1);
      chk("rst_frame", 8'(frame), 8'h0);
      step(3);
      greset = 0;
      repeat (20) begin
         step(1);
         chk("idle_an", 8'(an), 8'hF);
         chk("idle_seg", 8'(seg), 8'h7F);
         chk("idle_dp", 8'(dp), 8'h1);
         chk("idle_frame", 8'(frame), 8'h0);
      end
      data_in = 16'h1234; dp_in = 4'b0100; load = 1;
      step(1);
      load = 0;
      adv(4'b1110, 7'b1000000, 1, 0);
      adv(4'b1101, 7'b1000000, 1, 0);
      adv(4'b1011, 7'b1000000, 1, 0);
      adv(4'b0111, 7'b1000000, 1, 0);
      adv(4'b1110, 7'b0011001, 1, 1);
      adv(4'b1101, 7'b0110000, 1, 0);
      adv(4'b1011, 7'b0100100, 0, 0);
      adv(4'b0111, 7'b1111001, 1, 0);
      digsel = 1;
      step(1);
      chk("held_frame", 8'(frame), 8'h1);
      step(9);
      chk("held_an", 8'(an), 8'b1110);
      digsel = 0;
      step(5);
      chk("held_an_after", 8'(an), 8'b1110);
      chk("held_seg", 8'(seg), 8'(7'b0011001));
      data_in = 16'hAAAA; dp_in = 4'b0000; load = 1;
      step(1);
      load = 0;
      adv(4'b1101, 7'b0110000, 1, 0);
      data_in = 16'h5555; load = 1;
      step(1);
      load = 0;
      adv(4'b1011, 7'b0100100, 0, 0);
      adv(4'b0111, 7'b1111001, 1, 0);
      adv(4'b1110, 7'b0010010, 1, 1);
      adv(4'b1101, 7'b0010010, 1, 0);
      data_in = 16'h0070; load = 1;
      step(1);
      load = 0;
      adv(4'b1011, 7'b0010010, 1, 0);
      adv(4'b0111, 7'b0010010, 1, 0);
      adv(4'b1110, 7'b1000000, 1, 1);
      lzb = 1;
      adv(4'b1101, 7'b1111000, 1, 0);
      adv(4'b1011, 7'b1111111, 1, 0);
      lzb = 0;
      step(1);
      chk("lzb_off_d2", 8'(seg), 8'(7'b1000000));
      lzb = 1;
      adv(4'b0111, 7'b1111111, 1, 0);
      lzb = 0;
      step(1);
      chk("lzb_off_d3", 8'(seg), 8'(7'b1000000));
      lzb = 1;
      adv(4'b1110, 7'b1000000, 1, 1);
      lzb = 0;
      adv(4'b1101, 7'b1111000, 1, 0);
      adv(4'b1011, 7'b1000000, 1, 0);
      adv(4'b0111, 7'b1000000, 1, 0);
      data_in = 16'h8F0A; dp_in = 4'b1000; load = 1;
      adv(4'b1110, 7'b0001000, 1, 1);
      adv(4'b1101, 7'b1000000, 1, 0);
      adv(4'b1011, 7'b0001110, 1, 0);
      adv(4'b0111, 7'b0000000, 0, 0);
      digsel = 1;
      step(1);
      digsel = 0;
      chk("pre_rst_frame", 8'(frame), 8'h1);
      chk("pre_rst_an", 8'(an), 8'hF);
      greset = 1;
      #1;
      chk("async_an", 8'(an), 8'hF);
      chk("async_seg", 8'(seg), 8'h7F);
      chk("async_dp", 8'(dp), 8'h1);
      chk("async_frame", 8'(frame), 8'h0);
      chk("async_an_b0", 8'(an1), 8'hF);
      step(2);
      greset = 0;
      step(2);
      chk("post_rst_an", 8'(an), 8'hF);
      digsel = 1;
      step(1);
      digsel = 0;
      chk("b0_first_blank", 8'(an), 8'hF);
      chk("b0_first_an", 8'(an1), 8'b1110);
      chk("b0_first_seg", 8'(seg1), 8'(7'b1000000));
      chk("b0_first_frame", 8'(frame1), 8'h0);
      step(2);
      chk("lost_an", 8'(an), 8'b1110);
      chk("lost_seg", 8'(seg), 8'(7'b1000000));
      digsel = 1;
      step(1);
      digsel = 0;
      chk("b0_next_an", 8'(an1), 8'b1101);
      chk("b2_next_blank", 8'(an), 8'hF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
